display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, clk cycles each digit is held (legal range 2..2^20).
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port value_in  input  16  four BCD/hex nibbles; [3:0] is digit 0 (rightmost).
REQ-005 SHALL provide port load  input  1  single-cycle strobe capturing value_in.
REQ-006 SHALL provide port blank_lz  input  1  leading-zero blanking enable.
REQ-007 SHALL provide port digit_out  output  4  nibble for the downstream seven-segment decoder.
REQ-008 SHALL provide port anode_n  output  4  active-low digit enables; bit i drives digit i.
REQ-009 SHALL provide port pending  output  1  high while a loaded value awaits the frame boundary.
REQ-010 SHALL provide port frame_done  output  1  one-cycle pulse when digit 3 hands over to digit 0.

Function
REQ-011 SHALL contain a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; "tick" = prescaler at REFRESH_DIV-1.
REQ-012 SHALL contain a 2-bit digit index that advances 0->1->2->3->0 on each tick only.
REQ-013 SHALL hold a shadow register and a display register, each 16 bits.
REQ-014 load=1 SHALL write value_in to shadow and set pending on the same edge; a load while pending overwrites shadow (last write wins).
REQ-015 On a tick with index=3 (frame boundary), SHALL copy shadow to display, clear pending, and pulse frame_done for exactly one cycle.
REQ-016 load coinciding with a frame boundary SHALL transfer value_in directly to display and leave pending=0.
REQ-017 Display register SHALL never change other than at a frame boundary (no mid-frame tearing).
REQ-018 digit_out and anode_n SHALL be registered, reflecting the index and display register with one cycle of latency.
REQ-019 anode_n SHALL be one-hot low: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-020 digit_out SHALL equal display[4*i+3:4*i] for current index i.
REQ-021 With blank_lz=1, digit i (i=1..3) SHALL be blanked (anode_n=1111, digit_out=0000) when display nibbles i..3 are all zero; digit 0 is never blanked.
REQ-022 With blank_lz=0, no digit SHALL be blanked.
REQ-023 blank_lz SHALL be sampled every cycle; a change takes effect on the next output register update.
REQ-024 Prescaler and index SHALL free-run irrespective of load and pending.

Reset
REQ-025 reset=0 at a rising edge SHALL set prescaler=0, index=0, shadow=0, display=0, pending=0, frame_done=0, digit_out=0000, anode_n=1111.
REQ-026 reset asserted mid-frame or with pending=1 SHALL discard the pending value; no frame_done results.
REQ-027 First edge after reset release SHALL drive anode_n=1110, digit_out=0000; first tick occurs REFRESH_DIV edges after release.
REQ-028 reset SHALL take priority over load and tick on the same edge.

Verification (REFRESH_DIV=4)
REQ-029 Reset then idle 32 cycles -> anode_n sequence 1110,1101,1011,0111 each held 4 cycles; digit_out 0000; frame_done every 16 cycles.
REQ-030 load value_in=16'h1234 mid-frame -> pending=1 until next boundary; following frame digit_out 4,3,2,1 on anodes 1110,1101,1011,0111; pending=0.
REQ-031 load 16'hAAAA then 16'h5555 in same frame -> only 5,5,5,5 displayed; AAAA never appears.
REQ-032 blank_lz=1, display 16'h0007 -> anodes 1110 with digit 7, then 1111 for digits 1-3; blank_lz=0 -> digits 0,0,0 shown.
REQ-033 load 16'h9876 on the index=3 tick edge -> pending stays 0, next frame shows 6,7,8,9; frame_done one cycle.
REQ-034 reset pulse while pending=1 -> outputs 1111/0000, pending=0, following frames show 0000.

Source files
------------

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - four-digit multiplexed display scanner with frame-synchronous update
module display_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  digit_out,
    output logic [3:0]  anode_n,
    output logic        pending,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    index;
    logic [15:0]   shadow;
    logic [15:0]   display;
    logic          tick;
    logic          boundary;
    logic [15:0]   upper;
    logic [3:0]    nibble;
    logic          blank;

    assign tick     = (prescaler == LAST);
    assign boundary = tick && (index == 2'd3);

    // Free-running prescaler and digit index; neither cares about load or pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler <= '0;
            index     <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            index     <= index + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Double buffering: loads land in shadow, display only moves at the frame boundary.
    // A load on the boundary edge bypasses shadow so it is not held for a whole extra frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (load) begin
                shadow <= value_in;
            end
            if (boundary) begin
                display <= load ? value_in : shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select the current nibble and decide leading-zero blanking from the nibbles at and above it.
    always_comb begin
        upper  = display >> {index, 2'b00};
        nibble = upper[3:0];
        blank  = blank_lz && (index != 2'd0) && (upper == 16'd0);
    end

    // Registered drive to the segment decoder and anodes, one cycle behind the index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_out <= 4'h0;
            anode_n   <= 4'hF;
        end else if (blank) begin
            digit_out <= 4'h0;
            anode_n   <= 4'hF;
        end else begin
            digit_out <= nibble;
            anode_n   <= ~(4'b0001 << index);
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_out;
    logic [3:0]  anode_n;
    logic        pending;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // reference state: edges since reset release, double-buffered values
    int          k;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_pend;
    logic        blz;

    display_scanner #(.REFRESH_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .value_in(value_in),
        .load(load),
        .blank_lz(blank_lz),
        .digit_out(digit_out),
        .anode_n(anode_n),
        .pending(pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        k        = 0;
        m_disp   = 16'h0;
        m_shadow = 16'h0;
        m_pend   = 1'b0;
        check4("rst_anode", anode_n, 4'hF);
        check4("rst_digit", digit_out, 4'h0);
        check1("rst_pending", pending, 1'b0);
        check1("rst_frame_done", frame_done, 1'b0);
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare after the edge.
    task automatic step(input logic ld, input logic [15:0] v);
        int          idx;
        logic [3:0]  exp_an;
        logic [3:0]  exp_dg;
        logic [15:0] hi;
        logic        bnd;
        load     = ld;
        value_in = v;
        blank_lz = blz;
        // digit shown after this edge is the index that was current before it
        idx = (k / 4) % 4;
        hi  = m_disp >> (4 * idx);
        if (blz && idx != 0 && hi == 16'h0) begin
            exp_an = 4'hF;
            exp_dg = 4'h0;
        end else begin
            exp_an = 4'hF ^ (4'h1 << idx);
            exp_dg = hi[3:0];
        end
        k   = k + 1;
        bnd = (k % 16 == 0);
        if (bnd) begin
            m_disp = ld ? v : m_shadow;
            m_pend = 1'b0;
            if (ld) m_shadow = v;
        end else if (ld) begin
            m_shadow = v;
            m_pend   = 1'b1;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        check4("anode_n", anode_n, exp_an);
        check4("digit_out", digit_out, exp_dg);
        check1("pending", pending, m_pend);
        check1("frame_done", frame_done, bnd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic run_to_phase(input int ph);
        while (k % 16 != ph) step(1'b0, 16'h0);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        blank_lz = 1'b0;
        blz      = 1'b0;
        k        = 0;
        m_disp   = 16'h0;
        m_shadow = 16'h0;
        m_pend   = 1'b0;
        @(posedge clk);
        #1;

        // reset then 32 idle cycles
        do_reset();
        idle(32);

        // mid-frame load of 1234, shown in the following frame
        run_to_phase(5);
        step(1'b1, 16'h1234);
        idle(30);

        // two loads in one frame, last write wins
        run_to_phase(3);
        step(1'b1, 16'hAAAA);
        idle(4);
        step(1'b1, 16'h5555);
        idle(28);

        // leading-zero blanking on 0007, then disabled
        step(1'b1, 16'h0007);
        run_to_phase(0);
        blz = 1'b1;
        idle(17);
        blz = 1'b0;
        idle(16);

        // load exactly on the boundary edge
        run_to_phase(15);
        step(1'b1, 16'h9876);
        idle(18);

        // reset with a value pending
        run_to_phase(6);
        step(1'b1, 16'hBEEF);
        idle(3);
        do_reset();
        idle(34);

        // random loads, blanking toggles and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) blz = ~blz;
            if ($urandom_range(0, 127) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                logic [15:0] rv;
                rv = 16'($urandom);
                if ($urandom_range(0, 1) == 1) rv = rv & 16'h00FF;
                step(1'b1, rv);
            end else begin
                step(1'b0, 16'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
